bmf_addsub_seq: RTL and testbench

Sequential, parametrised block-minifloat adder/subtractor: takes two blocks (shared bias plus LENGTH minifloat elements) and returns their element-wise sum or difference as a renormalised block. It processes one element per cycle over a shared datapath instead of LENGTH parallel adders. It has valid/ready handshakes on input and output. It supports any NEXP/NMAN/bias width and reports bias overflow.

---
 rtl/bmf_addsub_seq.sv | 264 ++++++++++++++++++++++++++
 tb/tb_bmf_addsub_seq.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bmf_addsub_seq.sv
// -----------------------------------------------------------------------------
// bmf_addsub_seq
// Sequential block-minifloat adder/subtractor. Two blocks, each a shared
// unsigned bias plus LENGTH minifloat elements {sign, exp, man}, are added
// (or b1-b2) element by element over one shared datapath, then renormalised
// into a single result block with a fresh bias.
//
// Flow: IDLE -> ADD (LENGTH cycles) -> NORM (1 cycle) -> PACK (LENGTH cycles)
//       -> OUT (until out_ready).
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high; valid never depends on ready, and the producer holds its
// data stable while valid is high and ready is low.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   input handshake; in_ready is high only in IDLE
//   in_addsub           0 = b1+b2, 1 = b1-b2, captured with the blocks
//   in_b1, in_b2        {bias[BW], element[LENGTH-1] .. element[0]}
//   out_valid/out_ready result handshake
//   out_b               result block, same layout as the inputs
//   out_ovf             result bias saturated at 2^BW-1
//   busy                high whenever the FSM is not in IDLE
//   dbgState            current FSM state for checkers
// -----------------------------------------------------------------------------
module bmf_addsub_seq #(
    parameter int LENGTH = 8,
    parameter int NEXP   = 4,
    parameter int NMAN   = 3,
    parameter int BW     = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic                               in_addsub,
    input  logic [BW+LENGTH*(1+NEXP+NMAN)-1:0] in_b1,
    input  logic [BW+LENGTH*(1+NEXP+NMAN)-1:0] in_b2,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [BW+LENGTH*(1+NEXP+NMAN)-1:0] out_b,
    output logic                               out_ovf,
    output logic                               busy,
    output logic [2:0]                         dbgState
);

    localparam int EMAX = (1 << NEXP) - 1;
    localparam int SIZE = 1 + NEXP + NMAN;
    localparam int MW   = NMAN + EMAX;            // element magnitude width
    localparam int EW   = LENGTH * SIZE;          // element field width
    localparam int LW   = $clog2(MW + 1);         // holds a bit position 0..MW
    localparam int IW   = (LENGTH > 1) ? $clog2(LENGTH) : 1;
    localparam int SW   = ((BW > LW) ? BW : LW) + 2;  // signed bias/shift math
    localparam logic [IW-1:0] LAST = IW'(LENGTH - 1);

    typedef enum logic [2:0] {IDLE, ADD, NORM, PACK, OUT} stateT;

    stateT state, nextState;

    logic [IW-1:0]   idx;
    logic [EW-1:0]   b1Elems, b2Elems;
    logic [BW-1:0]   bias1, bias2;
    logic            subMode;
    // Two's complement sums: sign plus MW+1 magnitude bits.
    logic [MW+1:0]   sumBuf [LENGTH];
    logic [LW-1:0]   maxPos;
    logic            anyNz;
    logic signed [SW-1:0] kReg;       // >0 right shift, <0 left shift
    logic [BW-1:0]   outBias;
    logic            ovfReg;
    logic [EW-1:0]   outElems;

    // Magnitude of one element: hidden bit only for normal (e != 0) values,
    // denormals share the scale of e == 1.
    function automatic logic [MW-1:0] elemMag(input logic [SIZE-1:0] el);
        logic [NEXP-1:0] e;
        logic [NMAN-1:0] m;
        logic [MW-1:0]   base;
        e    = el[NMAN +: NEXP];
        m    = el[NMAN-1:0];
        base = MW'({(e != '0), m});
        if (e == '0) return base;
        return base << (e - 1'b1);
    endfunction

    // Align the smaller-bias operand; shifting past the width leaves nothing.
    function automatic logic [MW-1:0] alignShift(input logic [MW-1:0] v,
                                                  input logic [BW-1:0] d);
        if (32'(d) >= MW) return '0;
        return v >> d;
    endfunction

    function automatic logic [LW-1:0] leadPos(input logic [MW:0] v);
        logic [LW-1:0] p;
        p = '0;
        for (int i = 0; i <= MW; i++) begin
            if (v[i]) p = LW'(i);
        end
        return p;
    endfunction

    // ---------------- ADD datapath ----------------
    logic [SIZE-1:0] el1, el2;
    logic            b1Keep;
    logic [BW-1:0]   biasDiff, bmax;
    logic [MW-1:0]   mag1, mag2;
    logic [MW+1:0]   term1, term2, sumNow, sumAbsNow;
    logic [LW-1:0]   posNow;

    always_comb begin
        el1       = b1Elems[idx*SIZE +: SIZE];
        el2       = b2Elems[idx*SIZE +: SIZE];
        b1Keep    = (bias1 >= bias2);         // ties keep b1
        biasDiff  = b1Keep ? (bias1 - bias2) : (bias2 - bias1);
        bmax      = b1Keep ? bias1 : bias2;
        mag1      = b1Keep ? elemMag(el1) : alignShift(elemMag(el1), biasDiff);
        mag2      = b1Keep ? alignShift(elemMag(el2), biasDiff) : elemMag(el2);
        term1     = {2'b00, mag1};
        if (el1[SIZE-1]) term1 = -term1;
        term2     = {2'b00, mag2};
        if (el2[SIZE-1] ^ subMode) term2 = -term2;
        sumNow    = term1 + term2;
        sumAbsNow = sumNow[MW+1] ? -sumNow : sumNow;
        posNow    = leadPos(sumAbsNow[MW:0]);
    end

    // ---------------- NORM datapath ----------------
    logic signed [SW-1:0] bmaxS, kRaw, bSum, kNext, satS;
    logic [BW-1:0]        biasNext;
    logic                 ovfNext;

    always_comb begin
        bmaxS    = $signed(SW'(bmax));
        kRaw     = $signed(SW'(maxPos)) - $signed(SW'(MW - 1));
        satS     = $signed(SW'({BW{1'b1}}));
        bSum     = bmaxS + kRaw;
        biasNext = bSum[BW-1:0];
        kNext    = kRaw;
        ovfNext  = 1'b0;
        if (!anyNz) begin
            biasNext = '0;
            kNext    = '0;
        end else if (bSum[SW-1]) begin
            // Bias cannot go negative: use up only the available bias.
            biasNext = '0;
            kNext    = -bmaxS;
        end else if (bSum > satS) begin
            biasNext = '1;
            kNext    = satS - bmaxS;
            ovfNext  = 1'b1;
        end
    end

    // ---------------- PACK datapath ----------------
    logic [MW+1:0]   packSum, negSum;
    logic [MW:0]     packAbs, shifted, mTmp;
    logic [SW-1:0]   kMag;
    logic [LW-1:0]   packPos;
    logic [NEXP-1:0] eOut;
    logic [NMAN-1:0] mOut;
    logic            sOut;
    logic [SIZE-1:0] packEl;

    always_comb begin
        packSum = sumBuf[idx];
        negSum  = -packSum;
        packAbs = packSum[MW+1] ? negSum[MW:0] : packSum[MW:0];
        kMag    = kReg[SW-1] ? SW'(-kReg) : SW'(kReg);
        shifted = kReg[SW-1] ? (packAbs << kMag) : (packAbs >> kMag);
        packPos = leadPos(shifted);
        sOut    = packSum[MW+1];
        eOut    = '0;
        mOut    = shifted[NMAN-1:0];
        mTmp    = '0;
        if (shifted[MW]) begin
            // Only reachable when the bias saturated: clamp to largest value.
            eOut = '1;
            mOut = '1;
        end else if (|(shifted >> NMAN)) begin
            eOut = NEXP'(packPos - LW'(NMAN - 1));
            mTmp = shifted >> (packPos - LW'(NMAN));
            mOut = mTmp[NMAN-1:0];
        end
        if (shifted == '0) sOut = 1'b0;
        packEl = {sOut, eOut, mOut};
    end

    // ---------------- FSM ----------------
    always_comb begin
        nextState = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) nextState = ADD;
            end
            ADD:  if (idx == LAST) nextState = NORM;
            NORM: nextState = PACK;
            PACK: if (idx == LAST) nextState = OUT;
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            maxPos   <= '0;
            anyNz    <= 1'b0;
            kReg     <= '0;
            outBias  <= '0;
            ovfReg   <= 1'b0;
            outElems <= '0;
        end else begin
            state <= nextState;
            case (state)
                IDLE: if (in_valid) begin
                    idx    <= '0;
                    maxPos <= '0;
                    anyNz  <= 1'b0;
                end
                ADD: begin
                    idx    <= (idx == LAST) ? '0 : idx + 1'b1;
                    if (posNow > maxPos) maxPos <= posNow;
                    anyNz  <= anyNz | (|sumAbsNow);
                end
                NORM: begin
                    kReg    <= kNext;
                    outBias <= biasNext;
                    ovfReg  <= ovfNext;
                    idx     <= '0;
                end
                PACK: begin
                    outElems[idx*SIZE +: SIZE] <= packEl;
                    idx <= (idx == LAST) ? '0 : idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Operand and sum storage needs no reset: always written before use.
    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid) begin
            b1Elems <= in_b1[EW-1:0];
            b2Elems <= in_b2[EW-1:0];
            bias1   <= in_b1[EW +: BW];
            bias2   <= in_b2[EW +: BW];
            subMode <= in_addsub;
        end
        if (state == ADD) sumBuf[idx] <= sumNow;
    end

    assign out_b    = {outBias, outElems};
    assign out_ovf  = ovfReg;
    assign dbgState = state;

endmodule

// File: tb/tb_bmf_addsub_seq.sv
// -----------------------------------------------------------------------------
// tb_bmf_addsub_seq
// Self-checking bench for bmf_addsub_seq (LENGTH=8, NEXP=4, NMAN=3, BW=8).
// Expected results are pushed into expQ when a block is accepted and popped
// by a monitor when the DUT hands its result over.
// -----------------------------------------------------------------------------
module tb_bmf_addsub_seq;

    localparam int LENGTH = 8;
    localparam int NEXP   = 4;
    localparam int NMAN   = 3;
    localparam int BW     = 8;
    localparam int SIZE   = 1 + NEXP + NMAN;
    localparam int EMAX   = (1 << NEXP) - 1;
    localparam int MW     = NMAN + EMAX;
    localparam int BLKW   = BW + LENGTH * SIZE;
    localparam int OW     = BLKW + 1;             // {ovf, block}

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic            in_addsub;
    logic [BLKW-1:0] in_b1, in_b2;
    logic            out_valid;
    logic            out_ready;
    logic [BLKW-1:0] out_b;
    logic            out_ovf;
    logic            busy;
    logic [2:0]      dbgState;

    bmf_addsub_seq #(.LENGTH(LENGTH), .NEXP(NEXP), .NMAN(NMAN), .BW(BW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_addsub (in_addsub),
        .in_b1     (in_b1),
        .in_b2     (in_b2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_b     (out_b),
        .out_ovf   (out_ovf),
        .busy      (busy),
        .dbgState  (dbgState)
    );

    // ---------------- clock / cycle counter ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cycleCnt = 0;
    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // ---------------- checking ----------------
    int nChecks = 0;
    int nFails  = 0;
    logic [OW-1:0] expQ [$];
    int acceptCyc;

    task automatic checkVal(input string tag, input logic [OW-1:0] got,
                            input logic [OW-1:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Monitor: inputs change only at posedge+2, so at negedge a high
    // out_valid/out_ready pair means the result transfers at the next edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (expQ.size() == 0) checkVal("unexpected_out", OW'(1), OW'(0));
            else checkVal("result", {out_ovf, out_b}, expQ.pop_front());
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [BLKW-1:0] mkMixed(input logic [BW-1:0] bias,
                                                 input logic [SIZE-1:0] elEven,
                                                 input logic [SIZE-1:0] elOdd);
        logic [BLKW-1:0] r;
        for (int i = 0; i < LENGTH; i++) r[i*SIZE +: SIZE] = (i % 2 == 0) ? elEven : elOdd;
        r[BLKW-1 -: BW] = bias;
        return r;
    endfunction

    function automatic logic [BLKW-1:0] mkBlock(input logic [BW-1:0] bias,
                                                 input logic [SIZE-1:0] el);
        return mkMixed(bias, el, el);
    endfunction

    function automatic longint decodeMag(input logic [NEXP-1:0] e, input logic [NMAN-1:0] m);
        if (e == 0) return longint'(m);
        return (longint'(m) + (longint'(1) << NMAN)) << (int'(e) - 1);
    endfunction

    // Reference model working on plain integers.
    function automatic logic [OW-1:0] refModel(input logic [BLKW-1:0] a,
                                               input logic [BLKW-1:0] b,
                                               input logic sub);
        longint sums [LENGTH];
        longint ma, mb, maxAbs, av;
        int ba, bb, bmax, d, lp, k, bo, p;
        logic ovf, sa, sb, so;
        logic [NEXP-1:0] eo;
        logic [NMAN-1:0] mo;
        logic [BLKW-1:0] r;
        ba   = int'(a[BLKW-1 -: BW]);
        bb   = int'(b[BLKW-1 -: BW]);
        bmax = (ba >= bb) ? ba : bb;
        d    = (ba >= bb) ? ba - bb : bb - ba;
        maxAbs = 0;
        for (int i = 0; i < LENGTH; i++) begin
            ma = decodeMag(a[i*SIZE+NMAN +: NEXP], a[i*SIZE +: NMAN]);
            mb = decodeMag(b[i*SIZE+NMAN +: NEXP], b[i*SIZE +: NMAN]);
            sa = a[i*SIZE+SIZE-1];
            sb = b[i*SIZE+SIZE-1] ^ sub;
            if (ba >= bb) mb = (d >= MW) ? 0 : (mb >> d);
            else          ma = (d >= MW) ? 0 : (ma >> d);
            sums[i] = (sa ? -ma : ma) + (sb ? -mb : mb);
            av = (sums[i] < 0) ? -sums[i] : sums[i];
            if (av > maxAbs) maxAbs = av;
        end
        r = '0;
        if (maxAbs == 0) return {1'b0, r};
        lp = 0;
        while ((maxAbs >> (lp + 1)) != 0) lp++;
        k   = lp - (MW - 1);
        bo  = bmax + k;
        ovf = 1'b0;
        if (bo < 0) begin
            bo = 0;
            k  = -bmax;
        end else if (bo > (1 << BW) - 1) begin
            bo  = (1 << BW) - 1;
            k   = bo - bmax;
            ovf = 1'b1;
        end
        for (int i = 0; i < LENGTH; i++) begin
            av = (sums[i] < 0) ? -sums[i] : sums[i];
            av = (k >= 0) ? (av >> k) : (av << (-k));
            p = 0;
            while ((av >> (p + 1)) != 0) p++;
            if (av >= (longint'(1) << MW)) begin
                eo = '1;
                mo = '1;
            end else if (av >= (longint'(1) << NMAN)) begin
                eo = NEXP'(p - NMAN + 1);
                mo = NMAN'(av >> (p - NMAN));
            end else begin
                eo = '0;
                mo = NMAN'(av);
            end
            so = (sums[i] < 0) && (av != 0);
            r[i*SIZE +: SIZE] = {so, eo, mo};
        end
        r[BLKW-1 -: BW] = BW'(bo);
        return {ovf, r};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic startBlock(input logic [BLKW-1:0] a, input logic [BLKW-1:0] b,
                              input logic sub, input logic [OW-1:0] expv);
        int w;
        @(posedge clk); #2;
        in_b1 = a; in_b2 = b; in_addsub = sub; in_valid = 1'b1;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 200) begin @(negedge clk); w++; end
        if (!in_ready) checkVal("accept_timeout", OW'(0), OW'(1));
        acceptCyc = cycleCnt;
        expQ.push_back(expv);
        @(posedge clk); #2;
        in_valid  = 1'b0;
        // Scramble inputs: the DUT must not sample them after the accept.
        in_b1     = BLKW'({$urandom(), $urandom(), $urandom()});
        in_b2     = BLKW'({$urandom(), $urandom(), $urandom()});
        in_addsub = ~sub;
    endtask

    task automatic waitOutput();
        int w;
        w = 0;
        @(negedge clk);
        while (!out_valid && w < 200) begin @(negedge clk); w++; end
        if (!out_valid) checkVal("out_timeout", OW'(0), OW'(1));
        else checkVal("latency", OW'(cycleCnt - acceptCyc), OW'(2 * LENGTH + 2));
    endtask

    task automatic sendBlock(input logic [BLKW-1:0] a, input logic [BLKW-1:0] b,
                             input logic sub, input logic [OW-1:0] expv);
        startBlock(a, b, sub, expv);
        waitOutput();
    endtask

    // ---------------- test sequence ----------------
    logic [BLKW-1:0] ra, rb;
    int rbias1, rbias2;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_addsub = 1'b0;
        in_b1 = '0; in_b2 = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        checkVal("rst_in_ready",  OW'(in_ready),  OW'(1));
        checkVal("rst_out_valid", OW'(out_valid), OW'(0));
        checkVal("rst_out_b",     {out_ovf, out_b}, OW'(0));
        checkVal("rst_busy",      OW'(busy),      OW'(0));
        @(posedge clk); #2; rst_n = 1'b1;

        // Equal biases, add: bias steps up by one.
        sendBlock(mkBlock(8'd10, 8'h78), mkBlock(8'd10, 8'h78), 1'b0, {1'b0, mkBlock(8'd11, 8'h78)});
        // Equal blocks, subtract: everything cancels.
        sendBlock(mkBlock(8'd10, 8'h78), mkBlock(8'd10, 8'h78), 1'b1, {1'b0, mkBlock(8'd0, 8'h00)});
        // Different biases: b2 aligned right by 2.
        sendBlock(mkBlock(8'd12, 8'h78), mkBlock(8'd10, 8'h78), 1'b0, {1'b0, mkBlock(8'd12, 8'h7A)});
        // Left shift limited by the available bias.
        sendBlock(mkBlock(8'd5, 8'h08), mkBlock(8'd0, 8'h00), 1'b0, {1'b0, mkBlock(8'd0, 8'h30)});
        // Bias overflow, positive and mixed-sign elements saturate.
        sendBlock(mkBlock(8'd255, 8'h78), mkBlock(8'd255, 8'h78), 1'b0, {1'b1, mkBlock(8'd255, 8'h7F)});
        sendBlock(mkMixed(8'd255, 8'h78, 8'hF8), mkMixed(8'd255, 8'h78, 8'hF8), 1'b0,
                  {1'b1, mkMixed(8'd255, 8'h7F, 8'hFF)});

        // Back-pressure: result held, input side closed, in_valid ignored.
        @(posedge clk); #2; out_ready = 1'b0;
        sendBlock(mkBlock(8'd12, 8'h78), mkBlock(8'd10, 8'h78), 1'b0, {1'b0, mkBlock(8'd12, 8'h7A)});
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #2;
            in_valid = (i % 2 == 0);
            in_b1    = mkBlock(8'd1, 8'h11);
            @(negedge clk);
            checkVal("stall_out_b",    {out_ovf, out_b}, {1'b0, mkBlock(8'd12, 8'h7A)});
            checkVal("stall_in_ready", OW'(in_ready),  OW'(0));
        end
        @(posedge clk); #2; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        checkVal("stall_idle_busy",  OW'(busy),        OW'(0));
        checkVal("stall_queue_size", OW'(expQ.size()), OW'(0));

        // Reset in the middle of ADD aborts with no output.
        startBlock(mkBlock(8'd10, 8'h78), mkBlock(8'd10, 8'h78), 1'b0, {1'b0, mkBlock(8'd11, 8'h78)});
        repeat (2) @(posedge clk);
        #2; rst_n = 1'b0;
        #1;
        checkVal("midrst_in_ready",  OW'(in_ready),  OW'(1));
        checkVal("midrst_out_valid", OW'(out_valid), OW'(0));
        checkVal("midrst_out_b",     {out_ovf, out_b}, OW'(0));
        checkVal("midrst_busy",      OW'(busy),      OW'(0));
        void'(expQ.pop_back());
        @(posedge clk); #2; rst_n = 1'b1;
        sendBlock(mkBlock(8'd12, 8'h78), mkBlock(8'd10, 8'h78), 1'b0, {1'b0, mkBlock(8'd12, 8'h7A)});

        // Random blocks against the reference model.
        for (int t = 0; t < 16; t++) begin
            rbias1 = $urandom_range(0, 255);
            rbias2 = rbias1 + $urandom_range(0, 12) - 6;
            if (t % 4 == 3) rbias2 = $urandom_range(0, 255);
            if (rbias2 < 0) rbias2 = 0;
            if (rbias2 > 255) rbias2 = 255;
            ra = BLKW'({$urandom(), $urandom(), $urandom()});
            rb = BLKW'({$urandom(), $urandom(), $urandom()});
            ra[BLKW-1 -: BW] = BW'(rbias1);
            rb[BLKW-1 -: BW] = BW'(rbias2);
            sendBlock(ra, rb, 1'(t % 2), refModel(ra, rb, 1'(t % 2)));
        end

        repeat (3) @(negedge clk);
        checkVal("final_queue_size", OW'(expQ.size()), OW'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
